mux_sel_sequencer: RTL and testbench

//   Scan controller sitting directly upstream of the 4:1 gate-level mux: drives its
//   sel0/sel1 lines through the enabled channels in ascending order and dwells a

---
 rtl/mux_sel_sequencer.sv | 145 ++++++++++++++
 tb/tb_mux_sel_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_sel_sequencer.sv
// mux_sel_sequencer: scan controller for a 4:1 mux.
// It steps the mux select lines through the enabled channels in ascending order
// and dwells DWELL cycles on each channel. It captures y at cycle SETTLE of each
// dwell and reports the four captured bits as one word after each completed scan.
//
// Handshake: there is no ready. sample_valid is a one-cycle strobe, and samples
// is valid in that cycle and holds until the next strobe. start is a request
// that is only taken in IDLE, and only with a non-zero ch_en.
module mux_sel_sequencer #(
    parameter int DWELL  = 4,
    parameter int SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] ch_en,
    input  logic       continuous,
    input  logic       y,
    output logic       sel0,
    output logic       sel1,
    output logic       busy,
    output logic [3:0] samples,
    output logic       sample_valid
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t     state;
    logic [1:0] ch;
    logic [7:0] cnt;
    logic [3:0] mask;
    logic [3:0] shadow;
    logic [3:0] shadow_nxt;
    logic       have_next;
    logic [1:0] next_ch;
    logic [1:0] first_ch;

    // Shadow including the bit captured this cycle, so that a capture on the
    // final dwell cycle still reaches samples.
    always_comb begin
        shadow_nxt = shadow;
        if (state == SCAN && cnt == 8'(SETTLE))
            shadow_nxt[ch] = y;
    end

    // Next higher enabled channel in the latched mask, if there is one.
    always_comb begin
        have_next = 1'b0;
        next_ch   = ch;
        for (int i = 3; i >= 0; i--) begin
            if (i > int'(ch) && mask[i]) begin
                have_next = 1'b1;
                next_ch   = 2'(i);
            end
        end
    end

    // Lowest enabled channel of the live ch_en, used when a scan begins.
    always_comb begin
        first_ch = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (ch_en[i])
                first_ch = 2'(i);
        end
    end

    // Scan FSM. All outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            ch           <= 2'd0;
            cnt          <= 8'd0;
            mask         <= 4'd0;
            shadow       <= 4'd0;
            sel0         <= 1'b0;
            sel1         <= 1'b0;
            busy         <= 1'b0;
            samples      <= 4'd0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            case (state)
                IDLE: begin
                    sel0 <= 1'b0;
                    sel1 <= 1'b0;
                    busy <= 1'b0;
                    if (start && (ch_en != 4'd0)) begin
                        mask   <= ch_en;
                        shadow <= 4'd0;
                        ch     <= first_ch;
                        cnt    <= 8'd0;
                        sel0   <= first_ch[1];
                        sel1   <= first_ch[0];
                        busy   <= 1'b1;
                        state  <= SCAN;
                    end
                end
                SCAN: begin
                    shadow <= shadow_nxt;
                    if (cnt == 8'(DWELL - 1)) begin
                        if (have_next) begin
                            ch   <= next_ch;
                            cnt  <= 8'd0;
                            sel0 <= next_ch[1];
                            sel1 <= next_ch[0];
                        end else begin
                            samples      <= shadow_nxt;
                            sample_valid <= 1'b1;
                            state        <= REPORT;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                REPORT: begin
                    if (continuous && (ch_en != 4'd0)) begin
                        mask   <= ch_en;
                        shadow <= 4'd0;
                        ch     <= first_ch;
                        cnt    <= 8'd0;
                        sel0   <= first_ch[1];
                        sel1   <= first_ch[0];
                        state  <= SCAN;
                    end else begin
                        sel0  <= 1'b0;
                        sel1  <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    sel0  <= 1'b0;
                    sel1  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Bench for mux_sel_sequencer. The 4:1 mux is modelled inline.
// With d0..d3 = 0,1,1,0, the mux data word is 4'b0110.
module tb_mux_sel_sequencer;

    localparam int DWELL = 4;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] ch_en;
    logic       continuous;
    logic       y;
    logic       sel0;
    logic       sel1;
    logic       busy;
    logic [3:0] samples;
    logic       sample_valid;

    logic [3:0] d_in;

    int tests;
    int errors;

    logic [3:0] exp_q[$];

    typedef struct {
        logic [3:0] en;
        logic [3:0] exp_samples;
    } vec_t;

    vec_t vecs[7];

    mux_sel_sequencer #(.DWELL(DWELL), .SETTLE(1)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .ch_en(ch_en),
        .continuous(continuous),
        .y(y),
        .sel0(sel0),
        .sel1(sel1),
        .busy(busy),
        .samples(samples),
        .sample_valid(sample_valid)
    );

    // 4:1 mux: sel0 is the MSB of the channel index.
    assign y = d_in[{sel0, sel1}];

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Run one scan. mid=1 changes ch_en and pulses start while the scan is running.
    task automatic run_scan(input logic [3:0] en, input logic [3:0] exp, input bit mid);
        logic [1:0] list[$];
        int n;
        int lat;
        int bad_sel;
        bit got;
        logic [3:0] e;
        list.delete();
        for (int i = 0; i < 4; i++) if (en[i]) list.push_back(2'(i));
        n = list.size();
        bad_sel = 0;
        got = 0;
        lat = -1;
        exp_q.push_back(exp);
        @(negedge clk);
        ch_en = en;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (mid && k == 2) begin
                ch_en = 4'b0001;
                start = 1'b1;
            end else if (mid && k == 3) begin
                start = 1'b0;
            end
            if (sample_valid) begin
                got = 1;
                lat = k;
                break;
            end
            if (k < n * DWELL) begin
                if ({sel0, sel1} !== list[k / DWELL] || busy !== 1'b1) bad_sel++;
            end
            @(negedge clk);
        end
        check($sformatf("sel_seq en=%b", en), bad_sel, 0);
        if (!got) begin
            tests++;
            errors++;
            $display("FAIL timeout en=%b: no sample_valid within 100 cycles", en);
            void'(exp_q.pop_front());
        end else begin
            check($sformatf("latency en=%b", en), lat, n * DWELL);
            e = exp_q.pop_front();
            check($sformatf("samples en=%b", en), int'(samples), int'(e));
            @(negedge clk);
            check($sformatf("valid_pulse en=%b", en), int'(sample_valid), 0);
            check($sformatf("idle_busy en=%b", en), int'(busy), 0);
            check($sformatf("idle_sel en=%b", en), int'({sel0, sel1}), 0);
            check($sformatf("samples_hold en=%b", en), int'(samples), int'(e));
        end
    endtask

    initial begin
        int nv;
        int vt[4];
        int bad;
        logic [3:0] e;
        tests = 0;
        errors = 0;
        rst_n = 1'b0;
        start = 1'b0;
        ch_en = 4'b0000;
        continuous = 1'b0;
        d_in = 4'b0110;

        vecs[0] = '{4'b1111, 4'b0110};
        vecs[1] = '{4'b1010, 4'b0010};
        vecs[2] = '{4'b0101, 4'b0100};
        vecs[3] = '{4'b0001, 4'b0000};
        vecs[4] = '{4'b1000, 4'b0000};
        vecs[5] = '{4'b0110, 4'b0110};
        vecs[6] = '{4'b1001, 4'b0000};

        // reset for 2 cycles
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_sel", int'({sel0, sel1}), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_samples", int'(samples), 0);
        check("rst_valid", int'(sample_valid), 0);

        // table-driven single scans
        for (int i = 0; i < 7; i++) run_scan(vecs[i].en, vecs[i].exp_samples, 1'b0);

        // start with an empty mask is ignored
        @(negedge clk);
        ch_en = 4'b0000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            if (busy !== 1'b0 || sample_valid !== 1'b0 || {sel0, sel1} !== 2'b00) bad++;
            @(negedge clk);
        end
        check("empty_mask_ignored", bad, 0);

        // mid-scan ch_en change and start pulse have no effect
        run_scan(4'b1111, 4'b0110, 1'b1);

        // Continuous mode. Raise d3 after channel 3 of scan 1 has been captured.
        // REPORT takes one cycle, so reports are spaced 16+1 cycles apart.
        exp_q.push_back(4'b0110);
        exp_q.push_back(4'b1110);
        @(negedge clk);
        ch_en = 4'b1111;
        continuous = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nv = 0;
        for (int k = 0; k < 70; k++) begin
            if (k == 15) d_in[3] = 1'b1;
            if (k == 20) continuous = 1'b0;
            if (sample_valid) begin
                if (nv < 4) vt[nv] = k;
                nv++;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check($sformatf("cont_samples_%0d", nv), int'(samples), int'(e));
                end else begin
                    check("cont_extra_report", 1, 0);
                end
            end
            @(negedge clk);
        end
        check("cont_reports", nv, 2);
        if (nv >= 2) begin
            check("cont_first_lat", vt[0], 16);
            check("cont_period", vt[1] - vt[0], 4 * DWELL + 1);
        end
        check("cont_end_busy", int'(busy), 0);
        exp_q.delete();
        d_in = 4'b0110;

        // asynchronous reset in the middle of a scan
        @(negedge clk);
        ch_en = 4'b1111;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        check("pre_rst_busy", int'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_sel", int'({sel0, sel1}), 0);
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_samples", int'(samples), 0);
        check("async_rst_valid", int'(sample_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_busy", int'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
